pipe_ctrl: RTL and testbench

Pipeline sequencer and hazard controller for the 5-stage MIPS32 core (IF, ID, EX, MEM, WB). It watches the instruction word held in each pipeline latch and the EX-stage branch condition. From these it drives per-latch load enables, bubble/flush controls and the PC-source select. It also runs the start/halt state machine and keeps stall and squash performance counters.

---
 rtl/mips_pkg.sv | 68 ++++++
 rtl/ir_decode.sv | 85 ++++++++
 rtl/pipe_ctrl.sv | 231 +++++++++++++++++++++++
 tb/tb_pipe_ctrl.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mips_pkg
// Description : Shared definitions for the 5-stage MIPS32 pipeline
//               controller. Holds the opcode encodings, the instruction field
//               slice positions, the NOP word, the sequencer state type and a
//               small helper for the ALU opcode groups.
// Revision    : 1.0  initial release
// ============================================================================
package mips_pkg;

    // Instruction field slice positions
    localparam int OP_MSB = 31;
    localparam int OP_LSB = 26;
    localparam int RS_MSB = 25;
    localparam int RS_LSB = 21;
    localparam int RT_MSB = 20;
    localparam int RT_LSB = 16;
    localparam int RD_MSB = 15;
    localparam int RD_LSB = 11;

    // Instruction word used for bubbles and flushes
    localparam logic [31:0] NOP = 32'h0000_0000;

    // Register-register ALU group: 000000 .. 000101
    localparam logic [5:0] OP_ADD  = 6'b000000;
    localparam logic [5:0] OP_SUB  = 6'b000001;
    localparam logic [5:0] OP_AND  = 6'b000010;
    localparam logic [5:0] OP_OR   = 6'b000011;
    localparam logic [5:0] OP_SLT  = 6'b000100;
    localparam logic [5:0] OP_MUL  = 6'b000101;

    // Register-immediate ALU group: 010000 .. 010101
    localparam logic [5:0] OP_ADDI = 6'b010000;
    localparam logic [5:0] OP_SUBI = 6'b010001;
    localparam logic [5:0] OP_ANDI = 6'b010010;
    localparam logic [5:0] OP_ORI  = 6'b010011;
    localparam logic [5:0] OP_SLTI = 6'b010100;
    localparam logic [5:0] OP_MULI = 6'b010101;

    // Memory, branch and control
    localparam logic [5:0] OP_LW   = 6'b110000;
    localparam logic [5:0] OP_SW   = 6'b110001;
    localparam logic [5:0] OP_BEQZ = 6'b110100;
    localparam logic [5:0] OP_BNEZ = 6'b110101;
    localparam logic [5:0] OP_HLT  = 6'b111111;

    // Upper three opcode bits that identify each ALU group
    localparam logic [2:0] GRP_RR  = 3'b000;
    localparam logic [2:0] GRP_RI  = 3'b010;

    // Sequencer states
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_DRAIN  = 2'd2,
        S_HALTED = 2'd3
    } state_e;

    // Both ALU groups occupy the first six codes of their eighth of the
    // opcode space, so membership is "upper bits match, lower bits <= 5".
    function automatic logic op_in_alu_group(input logic [5:0] op,
                                             input logic [2:0] grp);
        return (op[5:3] == grp) && (op[2:0] <= 3'd5);
    endfunction

endpackage : mips_pkg
`default_nettype wire

// File: rtl/ir_decode.sv
`default_nettype none
// ============================================================================
// Module      : ir_decode
// Description : Combinational register-usage decoder for one pipeline latch.
//               Reports whether the instruction writes a register (and
//               which), which source fields it reads, and whether it is a
//               conditional branch or HLT.
// Ports       : ir_i         instruction word held in the latch
//               writes_o     instruction writes a register
//               dest_o       destination register number (0 when none)
//               uses_rs_o    rs field is a source operand
//               uses_rt_o    rt field is a source operand
//               is_branch_o  BEQZ or BNEZ
//               is_hlt_o     HLT
// Revision    : 1.0  initial release
// ============================================================================
module ir_decode
    import mips_pkg::*;
(
    input  logic [31:0] ir_i,
    output logic        writes_o,
    output logic [4:0]  dest_o,
    output logic        uses_rs_o,
    output logic        uses_rt_o,
    output logic        is_branch_o,
    output logic        is_hlt_o
);

    logic [5:0] w_op;
    logic [4:0] w_rt;
    logic [4:0] w_rd;
    logic       w_unused;

    assign w_op = ir_i[OP_MSB:OP_LSB];
    assign w_rt = ir_i[RT_MSB:RT_LSB];
    assign w_rd = ir_i[RD_MSB:RD_LSB];

    // The rs number and the immediate/shift bits are not needed to classify
    // the instruction; the hazard comparator slices rs itself.
    assign w_unused = ^{ir_i[RS_MSB:RS_LSB], ir_i[RD_LSB-1:0]};

    always_comb begin
        writes_o    = 1'b0;
        dest_o      = 5'd0;
        uses_rs_o   = 1'b0;
        uses_rt_o   = 1'b0;
        is_branch_o = 1'b0;
        is_hlt_o    = 1'b0;

        if (op_in_alu_group(w_op, GRP_RR)) begin
            uses_rs_o = 1'b1;
            uses_rt_o = 1'b1;
            writes_o  = 1'b1;
            dest_o    = w_rd;
        end else if (op_in_alu_group(w_op, GRP_RI)) begin
            uses_rs_o = 1'b1;
            writes_o  = 1'b1;
            dest_o    = w_rt;
        end else begin
            unique case (w_op)
                OP_LW: begin
                    uses_rs_o = 1'b1;
                    writes_o  = 1'b1;
                    dest_o    = w_rt;
                end
                OP_SW: begin
                    uses_rs_o = 1'b1;
                    uses_rt_o = 1'b1;
                end
                OP_BEQZ, OP_BNEZ: begin
                    uses_rs_o   = 1'b1;
                    is_branch_o = 1'b1;
                end
                OP_HLT: begin
                    is_hlt_o = 1'b1;
                end
                default: begin
                    // Unused opcodes touch no registers.
                end
            endcase
        end
    end

endmodule : ir_decode
`default_nettype wire

// File: rtl/pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipe_ctrl
// Description : Pipeline sequencer and hazard controller for the 5-stage
//               MIPS32 core. Decodes the instruction in each pipeline latch,
//               resolves taken branches, HLT and RAW hazards in priority
//               order, drives latch enables / bubble / flush / PC select,
//               runs the IDLE-RUN-DRAIN-HALTED sequencer and keeps saturating
//               stall and squash counters.
// Ports       : clk, rst_n           clock, async active-low reset
//               start                one-cycle pulse leaving IDLE/HALTED
//               ir_if_id..ir_mem_wb  instructions in ID, EX, MEM, WB
//               cond_ex              EX-stage (A == 0)
//               en_if..en_wb         latch loads / register-file write
//               bubble_ex, flush_id  NOP insertion into ID/EX and IF/ID
//               pc_sel               1 = branch target, 0 = NPC
//               halted               registered HALTED indication
//               stall_cnt            RAW-stall cycles (saturating)
//               squash_cnt           taken branches (saturating)
// Revision    : 1.0  initial release
// ============================================================================
module pipe_ctrl
    import mips_pkg::*;
#(
    parameter bit WB_BYPASS = 1'b1,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [31:0]      ir_if_id,
    input  logic [31:0]      ir_id_ex,
    input  logic [31:0]      ir_ex_mem,
    input  logic [31:0]      ir_mem_wb,
    input  logic             cond_ex,
    output logic             en_if,
    output logic             en_id,
    output logic             en_ex,
    output logic             en_mem,
    output logic             en_wb,
    output logic             bubble_ex,
    output logic             flush_id,
    output logic             pc_sel,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] squash_cnt
);

    // Latch index: 0 = IF/ID (ID), 1 = ID/EX (EX), 2 = EX/MEM (MEM),
    // 3 = MEM/WB (WB).
    localparam int N_LATCH = 4;

    logic [31:0] w_ir        [N_LATCH];
    logic [3:0]  w_writes;
    logic [4:0]  w_dest      [N_LATCH];
    logic [3:0]  w_uses_rs;
    logic [3:0]  w_uses_rt;
    logic [3:0]  w_is_branch;
    logic [3:0]  w_is_hlt;

    assign w_ir[0] = ir_if_id;
    assign w_ir[1] = ir_id_ex;
    assign w_ir[2] = ir_ex_mem;
    assign w_ir[3] = ir_mem_wb;

    generate
        for (genvar g = 0; g < N_LATCH; g++) begin : g_dec
            ir_decode u_dec (
                .ir_i        (w_ir[g]),
                .writes_o    (w_writes[g]),
                .dest_o      (w_dest[g]),
                .uses_rs_o   (w_uses_rs[g]),
                .uses_rt_o   (w_uses_rt[g]),
                .is_branch_o (w_is_branch[g]),
                .is_hlt_o    (w_is_hlt[g])
            );
        end
    endgenerate

    // ------------------------------------------------------------------
    // RAW hazard compare: ID sources against each downstream writer.
    // ------------------------------------------------------------------
    logic [4:0] w_id_rs;
    logic [4:0] w_id_rt;
    logic [3:1] w_raw_hit;
    logic       w_raw;

    assign w_id_rs = ir_if_id[RS_MSB:RS_LSB];
    assign w_id_rt = ir_if_id[RT_MSB:RT_LSB];

    generate
        for (genvar s = 1; s < N_LATCH; s++) begin : g_haz
            // r0 is hardwired, so a write to it never creates a dependency.
            assign w_raw_hit[s] = w_writes[s] && (w_dest[s] != 5'd0) &&
                                  ((w_uses_rs[0] && (w_id_rs == w_dest[s])) ||
                                   (w_uses_rt[0] && (w_id_rt == w_dest[s])));
        end
    endgenerate

    // With a write-through register file the WB producer is already visible
    // to ID, so only EX and MEM need to hold the instruction back.
    generate
        if (WB_BYPASS) begin : g_wb_bypass
            assign w_raw = w_raw_hit[1] | w_raw_hit[2];
        end else begin : g_wb_check
            assign w_raw = w_raw_hit[1] | w_raw_hit[2] | w_raw_hit[3];
        end
    endgenerate

    // Decoder outputs that this controller never consults for a given latch.
    logic w_unused;
    assign w_unused = ^{w_writes[0], w_dest[0], w_dest[3], w_writes[3],
                        w_uses_rs[3:1], w_uses_rt[3:1],
                        w_is_branch[0], w_is_branch[3:2],
                        w_is_hlt[2:1], w_raw_hit[3]};

    // ------------------------------------------------------------------
    // Branch resolution: BNEZ differs from BEQZ only in the opcode LSB.
    // ------------------------------------------------------------------
    logic w_taken;
    assign w_taken = w_is_branch[1] && (ir_id_ex[OP_LSB] ? !cond_ex : cond_ex);

    // ------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------
    state_e           state_q;
    state_e           state_d;
    logic             halted_q;
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] squash_cnt_q;
    logic             stall_inc;
    logic             squash_inc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            halted_q <= (state_d == S_HALTED);
        end
    end

    always_comb begin
        state_d    = state_q;
        en_if      = 1'b0;
        en_id      = 1'b0;
        en_ex      = 1'b0;
        en_mem     = 1'b0;
        en_wb      = 1'b0;
        bubble_ex  = 1'b0;
        flush_id   = 1'b0;
        pc_sel     = 1'b0;
        stall_inc  = 1'b0;
        squash_inc = 1'b0;

        unique case (state_q)
            S_IDLE, S_HALTED: begin
                // PC and latches hold, so a restart from HALTED resumes at
                // the held PC.
                if (start) begin
                    state_d = S_RUN;
                end
            end

            S_RUN: begin
                en_id  = 1'b1;
                en_ex  = 1'b1;
                en_mem = 1'b1;
                en_wb  = 1'b1;
                if (w_taken) begin
                    // Squash both younger instructions (IF/ID and ID/EX).
                    en_if      = 1'b1;
                    pc_sel     = 1'b1;
                    flush_id   = 1'b1;
                    bubble_ex  = 1'b1;
                    squash_inc = 1'b1;
                end else if (w_is_hlt[0]) begin
                    // HLT advances into EX; nothing younger is fetched.
                    flush_id = 1'b1;
                    state_d  = S_DRAIN;
                end else if (w_raw) begin
                    bubble_ex = 1'b1;
                    stall_inc = 1'b1;
                end else begin
                    en_if = 1'b1;
                end
            end

            S_DRAIN: begin
                // Only older instructions remain, so no hazards can arise.
                en_id    = 1'b1;
                en_ex    = 1'b1;
                en_mem   = 1'b1;
                en_wb    = 1'b1;
                flush_id = 1'b1;
                if (w_is_hlt[3]) begin
                    en_wb   = 1'b0;
                    state_d = S_HALTED;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Saturating performance counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q  <= '0;
            squash_cnt_q <= '0;
        end else begin
            if (stall_inc && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            end
            if (squash_inc && (squash_cnt_q != '1)) begin
                squash_cnt_q <= squash_cnt_q + CNT_W'(1);
            end
        end
    end

    assign halted     = halted_q;
    assign stall_cnt  = stall_cnt_q;
    assign squash_cnt = squash_cnt_q;

endmodule : pipe_ctrl
`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_ctrl
// Description : Self-checking bench for pipe_ctrl. A driver applies one
//               directed vector per cycle and queues the hand-computed
//               expected outputs; a monitor pops and compares on the falling
//               edge.
// Revision    : 1.0  initial release
// ============================================================================
module tb_pipe_ctrl;

    // Control bit order: en_if en_id en_ex en_mem en_wb bubble_ex flush_id pc_sel
    localparam logic [7:0] C_ZERO  = 8'b00000_000;
    localparam logic [7:0] C_RUN   = 8'b11111_000;
    localparam logic [7:0] C_STALL = 8'b01111_100;
    localparam logic [7:0] C_BR    = 8'b11111_111;
    localparam logic [7:0] C_HLTID = 8'b01111_010;
    localparam logic [7:0] C_DRAIN = 8'b01111_010;
    localparam logic [7:0] C_DLAST = 8'b01110_010;

    localparam logic [31:0] I_NOP   = 32'h0000_0000;
    localparam logic [31:0] I_ADD3  = 32'h0022_1800; // ADD r3,r1,r2
    localparam logic [31:0] I_SUB4  = 32'h0461_2000; // SUB r4,r3,r1
    localparam logic [31:0] I_LW5   = 32'hC025_0000; // LW r5,0(r1)
    localparam logic [31:0] I_LW0   = 32'hC020_0000; // LW r0,0(r1)
    localparam logic [31:0] I_ADDI5 = 32'h40A6_0001; // ADDI r6,r5,1
    localparam logic [31:0] I_ADDI0 = 32'h4006_0001; // ADDI r6,r0,1
    localparam logic [31:0] I_ADDI1 = 32'h4026_0001; // ADDI r6,r1,1
    localparam logic [31:0] I_SW5   = 32'hC425_0000; // SW r5,0(r1)
    localparam logic [31:0] I_BEQZ  = 32'hD020_0004; // BEQZ r1
    localparam logic [31:0] I_BNEZ  = 32'hD420_0004; // BNEZ r1
    localparam logic [31:0] I_HLT   = 32'hFC00_0000;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] ir_if_id;
    logic [31:0] ir_id_ex;
    logic [31:0] ir_ex_mem;
    logic [31:0] ir_mem_wb;
    logic        cond_ex;
    logic        en_if, en_id, en_ex, en_mem, en_wb;
    logic        bubble_ex, flush_id, pc_sel, halted;
    logic [15:0] stall_cnt;
    logic [15:0] squash_cnt;

    pipe_ctrl #(
        .WB_BYPASS (1'b1),
        .CNT_W     (16)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .ir_if_id   (ir_if_id),
        .ir_id_ex   (ir_id_ex),
        .ir_ex_mem  (ir_ex_mem),
        .ir_mem_wb  (ir_mem_wb),
        .cond_ex    (cond_ex),
        .en_if      (en_if),
        .en_id      (en_id),
        .en_ex      (en_ex),
        .en_mem     (en_mem),
        .en_wb      (en_wb),
        .bubble_ex  (bubble_ex),
        .flush_id   (flush_id),
        .pc_sel     (pc_sel),
        .halted     (halted),
        .stall_cnt  (stall_cnt),
        .squash_cnt (squash_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [7:0]  ctl;
        logic        halted;
        logic [15:0] stall;
        logic [15:0] squash;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string nm, input string fld,
                       input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s.%s actual=%h expected=%h", nm, fld, act, exp);
        end
    endtask

    // Monitor: the DUT presents a new set of outputs every cycle.
    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            mon_e = sb_q.pop_front();
            chk(mon_e.name, "ctl",
                {8'h00, en_if, en_id, en_ex, en_mem, en_wb, bubble_ex, flush_id, pc_sel},
                {8'h00, mon_e.ctl});
            chk(mon_e.name, "halted", {15'h0, halted}, {15'h0, mon_e.halted});
            chk(mon_e.name, "stall_cnt", stall_cnt, mon_e.stall);
            chk(mon_e.name, "squash_cnt", squash_cnt, mon_e.squash);
        end
    end

    // Driver: one vector per cycle; expected values describe that cycle.
    task automatic step(input string nm, input logic rn, input logic st,
                        input logic [31:0] id, input logic [31:0] ex,
                        input logic [31:0] mem, input logic [31:0] wb,
                        input logic c, input logic [7:0] ctl, input logic h,
                        input int stl, input int sq);
        exp_t e;
        @(posedge clk);
        #1;
        rst_n     = rn;
        start     = st;
        ir_if_id  = id;
        ir_id_ex  = ex;
        ir_ex_mem = mem;
        ir_mem_wb = wb;
        cond_ex   = c;
        e.name    = nm;
        e.ctl     = ctl;
        e.halted  = h;
        e.stall   = 16'(stl);
        e.squash  = 16'(sq);
        sb_q.push_back(e);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; cond_ex = 1'b0;
        ir_if_id = I_NOP; ir_id_ex = I_NOP; ir_ex_mem = I_NOP; ir_mem_wb = I_NOP;

        //    name          rn st ID       EX      MEM     WB     c    ctl      h  stl sq
        step("reset",       0, 0, I_NOP,   I_NOP,  I_NOP,  I_NOP, 0, C_ZERO,  0, 0, 0);
        step("idle",        1, 0, I_NOP,   I_NOP,  I_NOP,  I_NOP, 0, C_ZERO,  0, 0, 0);
        step("start",       1, 1, I_NOP,   I_NOP,  I_NOP,  I_NOP, 0, C_ZERO,  0, 0, 0);
        step("run",         1, 0, I_NOP,   I_NOP,  I_NOP,  I_NOP, 0, C_RUN,   0, 0, 0);
        step("rr_haz",      1, 0, I_SUB4,  I_ADD3, I_NOP,  I_NOP, 0, C_STALL, 0, 0, 0);
        step("rr_after",    1, 0, I_NOP,   I_NOP,  I_NOP,  I_NOP, 0, C_RUN,   0, 1, 0);
        step("ldu_ex",      1, 0, I_ADDI5, I_LW5,  I_NOP,  I_NOP, 0, C_STALL, 0, 1, 0);
        step("ldu_mem",     1, 0, I_ADDI5, I_NOP,  I_LW5,  I_NOP, 0, C_STALL, 0, 2, 0);
        step("ldu_wb",      1, 0, I_ADDI5, I_NOP,  I_NOP,  I_LW5, 0, C_RUN,   0, 3, 0);
        step("ldu_r0",      1, 0, I_ADDI0, I_LW0,  I_NOP,  I_NOP, 0, C_RUN,   0, 3, 0);
        step("ldu_nouse",   1, 0, I_ADDI1, I_LW5,  I_NOP,  I_NOP, 0, C_RUN,   0, 3, 0);
        step("sw_rt_haz",   1, 0, I_SW5,   I_LW5,  I_NOP,  I_NOP, 0, C_STALL, 0, 3, 0);
        step("sw_after",    1, 0, I_NOP,   I_NOP,  I_NOP,  I_NOP, 0, C_RUN,   0, 4, 0);
        step("beqz_t",      1, 0, I_NOP,   I_BEQZ, I_NOP,  I_NOP, 1, C_BR,    0, 4, 0);
        step("beqz_nt",     1, 0, I_NOP,   I_BEQZ, I_NOP,  I_NOP, 0, C_RUN,   0, 4, 1);
        step("bnez_t",      1, 0, I_NOP,   I_BNEZ, I_NOP,  I_NOP, 0, C_BR,    0, 4, 1);
        step("bnez_nt",     1, 0, I_NOP,   I_BNEZ, I_NOP,  I_NOP, 1, C_RUN,   0, 4, 2);
        step("br_vs_stall", 1, 0, I_SUB4,  I_BEQZ, I_ADD3, I_NOP, 1, C_BR,    0, 4, 2);
        step("br_after",    1, 0, I_NOP,   I_NOP,  I_NOP,  I_NOP, 0, C_RUN,   0, 4, 3);
        step("hlt_id",      1, 0, I_HLT,   I_NOP,  I_NOP,  I_NOP, 0, C_HLTID, 0, 4, 3);
        step("drain_ex",    1, 0, I_SUB4,  I_HLT,  I_ADD3, I_NOP, 0, C_DRAIN, 0, 4, 3);
        step("drain_mem",   1, 1, I_NOP,   I_NOP,  I_HLT,  I_NOP, 0, C_DRAIN, 0, 4, 3);
        step("drain_wb",    1, 0, I_NOP,   I_NOP,  I_NOP,  I_HLT, 0, C_DLAST, 0, 4, 3);
        step("halted",      1, 0, I_NOP,   I_NOP,  I_NOP,  I_NOP, 0, C_ZERO,  1, 4, 3);
        step("restart",     1, 1, I_NOP,   I_NOP,  I_NOP,  I_NOP, 0, C_ZERO,  1, 4, 3);
        step("resumed",     1, 0, I_NOP,   I_NOP,  I_NOP,  I_NOP, 0, C_RUN,   0, 4, 3);
        step("hlt_id2",     1, 0, I_HLT,   I_NOP,  I_NOP,  I_NOP, 0, C_HLTID, 0, 4, 3);
        step("drain2",      1, 0, I_NOP,   I_HLT,  I_NOP,  I_NOP, 0, C_DRAIN, 0, 4, 3);
        step("rst_drain",   0, 0, I_NOP,   I_NOP,  I_HLT,  I_NOP, 0, C_ZERO,  0, 0, 0);
        step("post_rst",    1, 0, I_NOP,   I_NOP,  I_NOP,  I_NOP, 0, C_ZERO,  0, 0, 0);
        step("start2",      1, 1, I_NOP,   I_NOP,  I_NOP,  I_NOP, 0, C_ZERO,  0, 0, 0);
        step("run2",        1, 0, I_NOP,   I_NOP,  I_NOP,  I_NOP, 0, C_RUN,   0, 0, 0);

        repeat (3) @(posedge clk);
        if (sb_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL scoreboard_drain actual=%0d pending expected=0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_pipe_ctrl
`default_nettype wire
